fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Downstream drain stage for the single-clock byte FIFO. Pops one word at a time through the FIFO read
//   port (rd_en / buf_out / buf_empty), then serialises it LSB-first as an asynchronous UART frame on tx.
//   Runs until the FIFO is empty or tx_en drops. Bridges buffered on-chip data to an off-chip serial line.
// PARAMETERS
//   DATA_WIDTH    8    bits per word/frame; must match the FIFO's FIFO_WIDTH
//   CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); must be >= 2
//   PARITY        0    0 = none, 1 = even, 2 = odd
//   STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//   clk         in   1           system clock; all logic on posedge
//   rst         in   1           synchronous, active-high reset
//   tx_en       in   1           1 = allowed to start new frames
//   fifo_empty  in   1           FIFO empty flag (buf_empty)
//   fifo_data   in   DATA_WIDTH  FIFO read data (buf_out), valid the cycle after an accepted rd_en
//   fifo_rd_en  out  1           FIFO read strobe, single-cycle pulse per word
//   tx          out  1           serial line, idle high
//   busy        out  1           1 from fetch until the end of the last stop bit
//   tx_done     out  1           one-cycle pulse on the final cycle of each stop phase
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0.
//     The baud counter, bit index and shift register are cleared.
//   Reset mid-frame aborts it. tx is 1 from the next edge. The partially sent word is lost and not re-read.
//   FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
//     IDLE:   tx=1. If tx_en && !fifo_empty, go to FETCH.
//     FETCH:  fifo_rd_en=1 for exactly this cycle (decoded from the registered state), busy=1. Go to LOAD.
//     LOAD:   fifo_data is valid. Capture it into the shift register, clear the baud counter. Go to START.
//     START:  tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//     DATA:   tx=shift[0] for CLKS_PER_BIT cycles, then shift right.
//             After DATA_WIDTH bits, go to PARITY (PARITY!=0) or STOP.
//     PARITY: tx = ^word (even) or ~^word (odd), computed on the captured word, for CLKS_PER_BIT cycles.
//     STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 on the last of them.
//             Then go to FETCH if tx_en && !fifo_empty, else IDLE.
//   Latency: tx_en=1 and !fifo_empty sampled in IDLE -> fifo_rd_en high 1 cycle later -> tx low 3 cycles later.
//   Frame length: (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles. Every bit is exactly CLKS_PER_BIT.
//   Back-to-back frames: 2 extra idle-high cycles (FETCH, LOAD) between the end of stop and the next start.
//   Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and wraps on the bit boundary.
//     It never overflows and is not free-running: it is cleared in IDLE and LOAD.
//   fifo_empty is only sampled in IDLE and on the last STOP cycle. It is never read while fifo_rd_en=1.
//     So a read is never issued to an empty FIFO, and there are never two strobes for one word.
//   tx_en falling mid-frame: the current frame completes normally. No new FETCH is issued.
//   tx_en toggling while in IDLE with an empty FIFO: no effect, fifo_rd_en stays 0.
//   The FIFO going empty as the last word is popped: finish that frame, then return to IDLE, busy=0.
//   The FIFO refilling during a frame: picked up at the end of the stop phase without returning to IDLE.
//   busy=1 in every state except IDLE. tx is registered, glitch-free, and 1 in every non-frame state.
// TESTING  (CLKS_PER_BIT=4, DATA_WIDTH=8 unless noted)
//   1 Reset: hold rst 2 cycles with arbitrary inputs -> tx=1, fifo_rd_en=0, busy=0, tx_done=0; state IDLE.
//   2 Single word 0xA5, PARITY=0: one fifo_rd_en pulse.
//     tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles. 40-cycle frame, tx_done at cycle 40, then IDLE.
//   3 Three words 0x01,0x80,0xFF queued, tx_en=1: 3 single-cycle rd_en pulses, 3 correct frames.
//     Exactly 2 idle-high cycles between frames. busy never drops until the last stop bit ends.
//   4 fifo_empty=1, tx_en=1 for 100 cycles -> fifo_rd_en never asserted, tx=1 throughout.
//   5 PARITY=1 with 0x07 -> parity bit 1. PARITY=2 with 0x07 -> parity bit 0.
//     STOP_BITS=2 -> stop phase is 8 cycles. Frame is 48 cycles.
//   6 Drop tx_en during DATA bit 3 with 2 words queued -> the frame completes, with no further rd_en.
//     rst pulsed in the same frame at bit 5 -> tx=1 the next cycle, busy=0, and the word is not resent.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame through the FIFO read
// port and serialises it LSB-first with optional parity and 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  par, par_n;
  logic                  tx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      par   <= par_n;
      tx    <= tx_n;
    end
  end

  // tx is registered from the next-state decision, so each level lands on the
  // same edge as the state change and every bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par;
    tx_n    = tx;
    tx_done = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        tx_n  = 1'b1;
        if (tx_en && !fifo_empty) state_n = S_FETCH;
      end
      S_FETCH: begin
        tx_n    = 1'b1;
        state_n = S_LOAD;
      end
      S_LOAD: begin
        shift_n = fifo_data;
        par_n   = (PARITY == 2) ? ~^fifo_data : ^fifo_data;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b0;
        state_n = S_START;
      end
      S_START: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shift[0];
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (PARITY != 0) begin
              tx_n    = par;
              state_n = S_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = shift_n[0];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b1;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (cnt == CNT_MAX) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            tx_done = 1'b1;
            idx_n   = '0;
            state_n = (tx_en && !fifo_empty) ? S_FETCH : S_IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  assign fifo_rd_en = (state == S_FETCH);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameterisations share one word stream; each
// checks tx/busy/tx_done/rd_en every cycle against a frame model built from the word.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b1;
  logic [7:0]  src [256];
  int unsigned wp = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int P = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int S = (g == 1) ? 2 : 1;

    int unsigned rp = 0;
    logic [7:0]  dat = '0;
    logic        rd, txo, bsy, dn, emp;
    int          ndone = 0;

    assign emp = (rp == wp);

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(P), .STOP_BITS(S)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (emp),
      .fifo_data  (dat),
      .fifo_rd_en (rd),
      .tx         (txo),
      .busy       (bsy),
      .tx_done    (dn)
    );

    // FIFO read port: data appears the cycle after an accepted strobe
    always @(posedge clk) begin
      if (rd && rp != wp) begin
        dat <= src[rp[7:0]];
        rp  <= rp + 1;
      end
    end

    logic q_tx [$];
    logic q_dn [$];
    logic exp_rd = 1'b0;
    logic armed  = 1'b0;

    always @(negedge clk) begin
      logic       et, ed, eb, lvl;
      logic [7:0] w;
      int         nb;
      if (armed) begin
        eb = (q_tx.size() != 0) || exp_rd;
        if (q_tx.size() != 0) begin
          et = q_tx.pop_front();
          ed = q_dn.pop_front();
        end else begin
          et = 1'b1;
          ed = 1'b0;
        end
        check($sformatf("rd_en[%0d]", g), {31'b0, rd}, {31'b0, exp_rd});
        check($sformatf("tx[%0d]", g), {31'b0, txo}, {31'b0, et});
        check($sformatf("busy[%0d]", g), {31'b0, bsy}, {31'b0, eb});
        check($sformatf("tx_done[%0d]", g), {31'b0, dn}, {31'b0, ed});
        if (dn) ndone++;
        if (rd) begin
          check($sformatf("rd_nonempty[%0d]", g), {31'b0, rp != wp}, 32'd1);
          w  = src[rp[7:0]];
          nb = 1 + 8 + ((P != 0) ? 1 : 0) + S;
          q_tx.push_back(1'b1);
          q_dn.push_back(1'b0);
          for (int b = 0; b < nb; b++) begin
            if (b == 0)                 lvl = 1'b0;
            else if (b <= 8)            lvl = w[b-1];
            else if (P != 0 && b == 9)  lvl = (P == 1) ? ^w : ~^w;
            else                        lvl = 1'b1;
            for (int c = 0; c < CPB; c++) begin
              q_tx.push_back(lvl);
              q_dn.push_back((b == nb - 1) && (c == CPB - 1));
            end
          end
        end
        exp_rd = !rst && (q_tx.size() == 0) && tx_en && (rp != wp);
      end
      if (rst) begin
        armed  = 1'b1;
        exp_rd = 1'b0;
        q_tx.delete();
        q_dn.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    src[wp[7:0]] = w;
    wp++;
  endtask

  function automatic bit all_idle();
    return (g_i[0].rp == wp) && !g_i[0].bsy &&
           (g_i[1].rp == wp) && !g_i[1].bsy &&
           (g_i[2].rp == wp) && !g_i[2].bsy;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    tx_en = 1'b1;
    @(negedge clk);
    while (!all_idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", {31'b0, n < budget}, 32'd1);
    step();
  endtask

  initial begin
    int n;
    // reset with tx_en high
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'b0, g_i[0].txo}, 32'd1);
    check("rst_rd", {31'b0, g_i[0].rd}, 32'd0);
    check("rst_busy", {31'b0, g_i[0].bsy}, 32'd0);
    check("rst_done", {31'b0, g_i[0].dn}, 32'd0);
    step();

    // single word, then three queued words back to back
    push(8'hA5);
    drain(300);
    tx_en = 1'b0;
    push(8'h01);
    push(8'h80);
    push(8'hFF);
    step();
    tx_en = 1'b1;
    drain(600);

    // empty FIFO with tx_en high and toggling: nothing may be fetched
    for (int i = 0; i < 100; i++) begin
      tx_en = (i < 50) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
    end
    tx_en = 1'b1;

    // parity / two-stop-bit word
    push(8'h07);
    drain(300);

    // tx_en drops in data bit 3, reset lands in data bit 5 of the same frame
    tx_en = 1'b0;
    step();
    push(8'h3C);
    push(8'hC3);
    tx_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!g_i[0].rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_seen", {31'b0, n < 20}, 32'd1);
    repeat (18) step();
    tx_en = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", {31'b0, g_i[0].txo}, 32'd1);
    check("abort_busy", {31'b0, g_i[0].bsy}, 32'd0);
    repeat (20) step();
    drain(300);

    // random traffic with occasional tx_en drops
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0 && wp < 200) push(8'($urandom));
      if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
      step();
    end
    drain(5000);

    // exactly one frame per stored word except the one aborted by reset
    check("frames[0]", g_i[0].ndone, wp - 1);
    check("frames[1]", g_i[1].ndone, wp - 1);
    check("frames[2]", g_i[2].ndone, wp - 1);
    check("rp_end[0]", g_i[0].rp, wp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
